reg_write_port_arbiter: RTL and testbench

- Shares the single register-file write port between two sources.
- Source 1 is the pipeline write-back stage. It has priority and is never buffered.
- Source 2 is any multi-cycle producer (LDM/POP sequencer, iterative multiplier) on a valid/ready interface. Its writes pass through a small FIFO and drain in cycles the pipeline leaves the port idle.
- An anti-starvation FSM stalls write-back to force a drain. The block sits between the write-back stage and the register-file write port.

---
 rtl/reg_write_port_arbiter_pkg.sv | 24 ++
 rtl/reg_write_port_arbiter_mc_write_fifo.sv | 62 ++++++
 rtl/reg_write_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_reg_write_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_port_arbiter_pkg
// Purpose  : Shared register-file types plus the write-port arbiter state type.
// Revision : 1.0 - initial release
// ============================================================================
package reg_write_port_arbiter_pkg;

    localparam int WORD       = 32;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic {
        RF_WRITE_DIS = 1'b0,
        RF_WRITE_EN  = 1'b1
    } reg_file_write_sig;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_write_port_arbiter_mc_write_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mc_write_fifo
// Purpose  : Synchronous FIFO for queued multi-cycle {addr, data} writes.
// Revision : 1.0 - initial release
// ============================================================================
module mc_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = DEPTH[c_ptr_w:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_full  = (r_count == c_full);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/reg_write_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_port_arbiter
// Purpose  : Shares the register-file write port between write-back (priority)
//            and a FIFO of multi-cycle writes with forced-drain anti-starvation.
//            Optional macro REG_WR_ARB_PENDING_MASK_EN builds pending_mask_o.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_port_arbiter
    import reg_write_port_arbiter_pkg::*;
#(
    parameter int MC_FIFO_DEPTH = 4,
    parameter int MAX_WAIT      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  reg_file_write_sig          wb_write_en_i,
    input  logic [ADDR_WIDTH-1:0]      wb_addr_i,
    input  logic [WORD-1:0]            wb_data_i,
    input  logic                       mc_valid_i,
    output logic                       mc_ready_o,
    input  logic [ADDR_WIDTH-1:0]      mc_addr_i,
    input  logic [WORD-1:0]            mc_data_i,
    output logic                       wb_stall_o,
    output reg_file_write_sig          rf_write_en_o,
    output logic [ADDR_WIDTH-1:0]      rf_addr_o,
    output logic [WORD-1:0]            rf_data_o,
    output logic                       mc_pending_o,
    output logic [2**ADDR_WIDTH-1:0]   pending_mask_o
);

    localparam int                    c_entry_w   = ADDR_WIDTH + WORD;
    localparam int                    c_cnt_w     = $clog2(MC_FIFO_DEPTH) + 1;
    localparam int                    c_wait_w    = $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0]   c_wait_last = c_wait_w'(MAX_WAIT - 1);
    localparam logic [c_cnt_w-1:0]    c_one       = c_cnt_w'(1);

    arb_state_t             r_state;
    logic [c_wait_w-1:0]    r_wait_cnt;
    logic                   r_wb_stall;

    logic                   w_full;
    logic                   w_empty;
    logic [c_entry_w-1:0]   w_head;
    logic [c_cnt_w-1:0]     w_count;
    logic                   w_wb_req;
    logic                   w_wb_grant;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_last;

    mc_write_fifo #(
        .DEPTH (MC_FIFO_DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({mc_addr_i, mc_data_i}),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_wb_req = (wb_write_en_i == RF_WRITE_EN);
    assign w_last   = (w_count == c_one);

    // Reset suppresses every port write so queued entries can never leak out.
    always_comb begin
        w_wb_grant = 1'b0;
        w_pop      = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    w_wb_grant = w_wb_req;
                WAIT:    begin
                    w_wb_grant = w_wb_req;
                    w_pop      = !w_wb_req;
                end
                FORCE:   w_pop = 1'b1;
                default: w_pop = 1'b0;
            endcase
        end
    end

    assign mc_ready_o = !w_full || w_pop;
    assign w_push     = mc_valid_i && mc_ready_o;

    always_comb begin
        rf_write_en_o = RF_WRITE_DIS;
        rf_addr_o     = '0;
        rf_data_o     = '0;
        if (w_pop) begin
            rf_write_en_o = RF_WRITE_EN;
            {rf_addr_o, rf_data_o} = w_head;
        end else if (w_wb_grant) begin
            rf_write_en_o = RF_WRITE_EN;
            rf_addr_o     = wb_addr_i;
            rf_data_o     = wb_data_i;
        end
    end

    // The counter holds losses already taken; the MAX_WAIT-th loss forces a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_wb_stall <= 1'b0;
        end else begin
            r_wb_stall <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_push) r_state <= WAIT;
                end
                WAIT: begin
                    if (w_wb_req) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == c_wait_last) begin
                            r_state    <= FORCE;
                            r_wb_stall <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= '0;
                        if (w_last && !w_push) r_state <= IDLE;
                    end
                end
                FORCE: begin
                    r_wait_cnt <= '0;
                    r_state    <= (w_last && !w_push) ? IDLE : WAIT;
                end
                default: begin
                    r_wait_cnt <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign wb_stall_o   = r_wb_stall;
    assign mc_pending_o = !w_empty;

`ifdef REG_WR_ARB_PENDING_MASK_EN
    for (genvar g_r = 0; g_r < 2**ADDR_WIDTH; g_r++) begin : g_pending
        logic [c_cnt_w-1:0] r_occ;
        logic               w_inc;
        logic               w_dec;

        assign w_inc = w_push && (mc_addr_i == ADDR_WIDTH'(g_r));
        assign w_dec = w_pop && (w_head[c_entry_w-1:WORD] == ADDR_WIDTH'(g_r));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_occ <= '0;
            end else if (w_inc && !w_dec) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_occ <= r_occ - 1'b1;
            end
        end

        assign pending_mask_o[g_r] = |r_occ;
    end
`else
    assign pending_mask_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_write_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_port_arbiter
// Purpose  : Directed and randomised self-checking bench with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_port_arbiter;
    import reg_write_port_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXW  = 3;
    localparam int NREG  = 2**ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [WORD-1:0]       d;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wb_req;
    reg_file_write_sig       wb_write_en;
    logic [ADDR_WIDTH-1:0]   wb_addr;
    logic [WORD-1:0]         wb_data;
    logic                    mc_valid;
    logic                    mc_ready;
    logic [ADDR_WIDTH-1:0]   mc_addr;
    logic [WORD-1:0]         mc_data;
    logic                    wb_stall;
    reg_file_write_sig       rf_we;
    logic [ADDR_WIDTH-1:0]   rf_addr;
    logic [WORD-1:0]         rf_data;
    logic                    mc_pending;
    logic [NREG-1:0]         pending_mask;

    assign wb_write_en = wb_req ? RF_WRITE_EN : RF_WRITE_DIS;

    always #5 clk = ~clk;

    reg_write_port_arbiter #(
        .MC_FIFO_DEPTH (DEPTH),
        .MAX_WAIT      (MAXW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_write_en_i  (wb_write_en),
        .wb_addr_i      (wb_addr),
        .wb_data_i      (wb_data),
        .mc_valid_i     (mc_valid),
        .mc_ready_o     (mc_ready),
        .mc_addr_i      (mc_addr),
        .mc_data_i      (mc_data),
        .wb_stall_o     (wb_stall),
        .rf_write_en_o  (rf_we),
        .rf_addr_o      (rf_addr),
        .rf_data_o      (rf_data),
        .mc_pending_o   (mc_pending),
        .pending_mask_o (pending_mask)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    int   losses;
    bit   force_now;
    bit   last_push;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: write-back wins unless a drain is forced; idle port drains the queue;
    // MAXW consecutive losses by a non-empty queue force the next cycle to drain.
    task automatic check_and_advance();
        bit              exp_we;
        ent_t            exp_w;
        bit              pop;
        bit              exp_ready;
        bit              nf;
        logic [NREG-1:0] exp_mask;
        exp_we   = 1'b0;
        exp_w    = '0;
        pop      = 1'b0;
        nf       = 1'b0;
        exp_mask = '0;
        if (!rst) begin
            if (force_now) pop = 1'b1;
            else if (wb_req) begin
                exp_we = 1'b1;
                exp_w  = {wb_addr, wb_data};
            end else if (q.size() > 0) pop = 1'b1;
            if (pop) begin
                exp_we = 1'b1;
                exp_w  = q[0];
            end
        end
        exp_ready = (q.size() < DEPTH) || pop;
`ifdef REG_WR_ARB_PENDING_MASK_EN
        foreach (q[i]) exp_mask[q[i].a] = 1'b1;
`endif
        check_value("rf_we",   64'(rf_we),     64'(exp_we));
        check_value("rf_addr", 64'(rf_addr),   64'(exp_w.a));
        check_value("rf_data", 64'(rf_data),   64'(exp_w.d));
        check_value("stall",   64'(wb_stall),  64'(force_now));
        check_value("ready",   64'(mc_ready),  64'(exp_ready));
        check_value("pending", 64'(mc_pending), 64'(q.size() > 0));
        check_value("mask",    64'(pending_mask), 64'(exp_mask));
        last_push = mc_valid && exp_ready && !rst;
        if (rst) begin
            q.delete();
            losses    = 0;
            force_now = 1'b0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                losses = 0;
            end else if (wb_req && q.size() > 0) begin
                losses++;
                if (losses == MAXW) nf = 1'b1;
            end
            if (last_push) q.push_back({mc_addr, mc_data});
            force_now = nf;
        end
    endtask

    task automatic finish_cycle();
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic set_in(input bit w, input int wa, input int wd, input bit v, input int ma, input int md);
        wb_req   = w;
        wb_addr  = ADDR_WIDTH'(wa);
        wb_data  = WORD'(wd);
        mc_valid = v;
        mc_addr  = ADDR_WIDTH'(ma);
        mc_data  = WORD'(md);
    endtask

    initial begin
        losses    = 0;
        force_now = 1'b0;
        last_push = 1'b0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_value("rst_stall", 64'(wb_stall), 64'd0);
        check_value("rst_ready", 64'(mc_ready), 64'd1);
        check_value("rst_pend",  64'(mc_pending), 64'd0);
        check_value("rst_mask",  64'(pending_mask), 64'd0);
        check_value("rst_we",    64'(rf_we), 64'd0);
        finish_cycle();

        // Write-back pass-through, zero latency
        set_in(1, 3, 'h11, 0, 0, 0);
        @(negedge clk);
        check_value("t1_we",   64'(rf_we), 64'd1);
        check_value("t1_addr", 64'(rf_addr), 64'd3);
        check_value("t1_data", 64'(rf_data), 64'h11);
        finish_cycle();

        // Single mc push drains one cycle later
        set_in(0, 0, 0, 1, 5, 'hAA);
        @(negedge clk);
        check_value("t2_we0", 64'(rf_we), 64'd0);
        finish_cycle();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_value("t2_addr", 64'(rf_addr), 64'd5);
        check_value("t2_data", 64'(rf_data), 64'hAA);
        check_value("t2_pend", 64'(mc_pending), 64'd1);
        finish_cycle();
        @(negedge clk);
        check_value("t2_pend0", 64'(mc_pending), 64'd0);
        finish_cycle();

        // Starvation: three losses then a forced drain, held wb follows
        set_in(1, 7, 'h77, 1, 5, 'h55);
        cycle();
        mc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("t3_nostall", 64'(wb_stall), 64'd0);
            check_value("t3_wbaddr",  64'(rf_addr), 64'd7);
            finish_cycle();
        end
        @(negedge clk);
        check_value("t3_stall", 64'(wb_stall), 64'd1);
        check_value("t3_force", 64'(rf_addr), 64'd5);
        finish_cycle();
        @(negedge clk);
        check_value("t3_after", 64'(rf_addr), 64'd7);
        check_value("t3_empty", 64'(mc_pending), 64'd0);
        finish_cycle();

        // Five back-to-back pushes under busy write-back, then drain
        for (int i = 0; i < 5; i++) begin
            int guard = 0;
            do begin
                if (!force_now) set_in(1, 9, 'h900 + i, 1, 8 + i, 'h100 + i);
                else begin
                    mc_valid = 1'b1;
                    mc_addr  = ADDR_WIDTH'(8 + i);
                    mc_data  = WORD'('h100 + i);
                end
                cycle();
                guard++;
            end while (!last_push && guard < 20);
            if (!last_push) check_value("t4_timeout", 64'd0, 64'd1);
        end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle();

        // Two queued writes to the same register
        set_in(1, 1, 'h1, 1, 2, 'h21);
        cycle();
        mc_data = 'h22;
        cycle();
        mc_valid = 1'b0;
        @(negedge clk);
`ifdef REG_WR_ARB_PENDING_MASK_EN
        check_value("t5_mask", 64'(pending_mask[2]), 64'd1);
`else
        check_value("t5_mask", 64'(pending_mask[2]), 64'd0);
`endif
        finish_cycle();
        wb_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check_value("t5_clear", 64'(pending_mask), 64'd0);

        // Reset while in FORCE with three entries queued
        set_in(1, 4, 'h44, 1, 6, 'h61);
        cycle();
        mc_data = 'h62;
        cycle();
        mc_data = 'h63;
        cycle();
        mc_valid = 1'b0;
        cycle();
        rst = 1'b1;
        @(negedge clk);
        check_value("t6_in_force", 64'(wb_stall), 64'd1);
        check_value("t6_rst_we",   64'(rf_we), 64'd0);
        finish_cycle();
        rst    = 1'b0;
        wb_req = 1'b0;
        @(negedge clk);
        check_value("t6_stall", 64'(wb_stall), 64'd0);
        check_value("t6_pend",  64'(mc_pending), 64'd0);
        check_value("t6_we",    64'(rf_we), 64'd0);
        finish_cycle();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            if (!force_now) begin
                wb_req  = ($urandom_range(0, 99) < 55);
                wb_addr = ADDR_WIDTH'($urandom);
                wb_data = WORD'($urandom);
            end
            mc_valid = ($urandom_range(0, 99) < 50);
            mc_addr  = ADDR_WIDTH'($urandom_range(0, 5));
            mc_data  = WORD'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
